operand_fetch: RTL

Operand fetch stage feeding the accelerator controller. On a one-cycle start pulse it reads two square operand matrices, A and then B, from memory over the AXI read channels, one 32-bit word per element. Each word is written into the local operand buffer that feeds the systolic array, and `read_done` is pulsed on completion. It sits between the controller and the AXI interconnect: the controller supplies addresses and dimensions, and this block answers with `read_done`.

---
 rtl/accel_pkg.sv | 23 ++
 rtl/elem_counter.sv | 34 +++
 rtl/operand_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator datapath: fetch FSM states, element/word sizing,
// AXI response and fixed single-beat AR attribute encodings.
package accel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_AR,
    A_R,
    B_AR,
    B_R,
    DONE
  } fetch_state_t;

  localparam int WORD_BYTES = 4;
  localparam int MAX_DIM    = 15;
  localparam int DIM_W      = 4;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [7:0] AR_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AR_SIZE_WORD  = 3'd2;
  localparam logic [1:0] AR_BURST_INCR = 2'b01;

endpackage

// File: rtl/elem_counter.sv
// Row-major element index with a terminal flag at N*N-1; idx_nxt wraps to 0 after the last element.
// Latency: idx updates on the cycle after inc; last/idx_nxt are combinational. No backpressure (inc is a strobe).
module elem_counter
  import accel_pkg::*;
#(
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [DIM_W-1:0] dim,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] idx_nxt,
  output logic             last
);

  logic [IDX_W-1:0] total;

  assign total   = IDX_W'(dim) * IDX_W'(dim);
  assign last    = (idx == total - 1'b1);
  assign idx_nxt = last ? '0 : idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx_nxt;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Fetches square matrices A then B word-by-word over AXI read (one outstanding single beat) into the operand buffer.
// Latency: 2 cycles/element minimum, read_done 1 cycle after last R beat; stalls on arready/rvalid, no buffer backpressure.
module operand_fetch
  import accel_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,

  input  logic              start,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DIM_W-1:0]  a_dim,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DIM_W-1:0]  b_dim,
  output logic              busy,
  output logic              read_done,
  output logic              read_err,

  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,

  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,

  output logic              buf_we,
  output logic              buf_sel,
  output logic [IDX_W-1:0]  buf_idx,
  output logic [DATA_W-1:0] buf_data
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [DIM_W-1:0]  a_n;
  logic [DIM_W-1:0]  b_n;

  logic              on_b;
  logic [DIM_W-1:0]  cur_dim;
  logic [ADDR_W-1:0] cur_base;
  logic [ADDR_W-1:0] next_addr;
  logic              r_hs;
  logic              cnt_clr;
  logic [IDX_W-1:0]  cnt_idx;
  logic [IDX_W-1:0]  cnt_idx_nxt;
  logic              cnt_last;

  assign m_axi_arlen   = AR_LEN_SINGLE;
  assign m_axi_arsize  = AR_SIZE_WORD;
  assign m_axi_arburst = AR_BURST_INCR;

  assign on_b     = (state == B_AR) || (state == B_R);
  assign cur_dim  = on_b ? b_n : a_n;
  assign cur_base = on_b ? b_base : a_base;
  assign r_hs     = m_axi_rready && m_axi_rvalid;
  assign cnt_clr  = (state == IDLE) && start;

  // Address of the element after the one being accepted now; wraps modulo 2^ADDR_W.
  assign next_addr = cur_base + ADDR_W'(cnt_idx_nxt) * ADDR_W'(WORD_BYTES);

  elem_counter #(
    .IDX_W (IDX_W)
  ) u_elem_counter (
    .clk     (M_AXI_ACLK),
    .rst_n   (M_AXI_ARESETN),
    .clr     (cnt_clr),
    .inc     (r_hs),
    .dim     (cur_dim),
    .idx     (cnt_idx),
    .idx_nxt (cnt_idx_nxt),
    .last    (cnt_last)
  );

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      a_base        <= '0;
      b_base        <= '0;
      a_n           <= '0;
      b_n           <= '0;
      busy          <= 1'b0;
      read_done     <= 1'b0;
      read_err      <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      buf_we        <= 1'b0;
      buf_sel       <= 1'b0;
      buf_idx       <= '0;
      buf_data      <= '0;
    end else begin
      buf_we    <= 1'b0;
      read_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_base   <= a_addr;
            b_base   <= b_addr;
            a_n      <= a_dim;
            b_n      <= b_dim;
            read_err <= 1'b0;
            busy     <= 1'b1;
            if (a_dim != '0) begin
              state         <= A_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= a_addr;
            end else if (b_dim != '0) begin
              state         <= B_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= b_addr;
            end else begin
              state     <= DONE;
              read_done <= 1'b1;
            end
          end
        end

        A_AR, B_AR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= (state == A_AR) ? A_R : B_R;
          end
        end

        A_R, B_R: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            buf_we       <= 1'b1;
            buf_sel      <= on_b;
            buf_idx      <= cnt_idx;
            buf_data     <= m_axi_rdata;
            if (m_axi_rresp != RESP_OKAY) begin
              read_err <= 1'b1;
            end
            if (!cnt_last) begin
              state         <= on_b ? B_AR : A_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= next_addr;
            end else if (!on_b && (b_n != '0)) begin
              state         <= B_AR;
              m_axi_arvalid <= 1'b1;
              m_axi_araddr  <= b_base;
            end else begin
              state     <= DONE;
              read_done <= 1'b1;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
